demultiplexer_1_to_8_16_bit_reg: RTL and testbench

- Registered 1-to-8 demultiplexer. It is the write-side counterpart of the 8-to-1 16-bit read selector in the single-cycle datapath.
- Routes one 16-bit data word to one of eight holding registers, chosen by a 3-bit select. Each register keeps its value until it is overwritten or cleared.
- Feeds the eight-input read selector. It also exposes per-slot valid flags and the index of the last slot written, for hazard and debug logic.

---
 rtl/demultiplexer_1_to_8_16_bit_reg.sv | 138 +++++++++++++
 tb/tb_demultiplexer_1_to_8_16_bit_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demultiplexer_1_to_8_16_bit_reg.sv
// ---------------------------------------------------------------------------
// demultiplexer_1_to_8_16_bit_reg
//
// Registered 1-to-8 demultiplexer. It is the write-side partner of the 8-to-1
// read selector. One WIDTH-bit word is routed into one of eight holding
// registers, chosen by {S2,S1,S0}. Each slot also carries a valid flag, and
// the index of the most recently written slot is tracked for hazard and debug
// logic.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears all state)
//   S2,S1,S0   slot select, S2 is the MSB
//   D          write data
//   WE         write enable, sampled on rising clk
//   CLR        synchronous clear of all slots; has priority over WE
//   Y0..Y7     held slot contents
//   V          per-slot valid flags (written since last reset/clear)
//   LAST       index of the most recently written slot
//
// Optional build macro:
//   REG0_ZERO_EN  slot 0 is hardwired to zero (RISC r0 semantics). Y0 and
//                 V[0] are constant 0, and a write to slot 0 changes nothing,
//                 including LAST.
//
// All outputs come straight from flops (or constants). There is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module demultiplexer_1_to_8_16_bit_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S2,
  input  logic             S1,
  input  logic             S0,
  input  logic [WIDTH-1:0] D,
  input  logic             WE,
  input  logic             CLR,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [WIDTH-1:0] Y4,
  output logic [WIDTH-1:0] Y5,
  output logic [WIDTH-1:0] Y6,
  output logic [WIDTH-1:0] Y7,
  output logic [7:0]       V,
  output logic [2:0]       LAST
);

  logic [2:0]       sel;
  logic [7:0]       wr_hit;
  logic             wr_any;
  logic [WIDTH-1:0] slot_q [8];
  logic [7:0]       valid_q;
  logic [2:0]       last_q;

  assign sel = {S2, S1, S0};

  // One-hot write strobe per slot. The case covers every select value and
  // falls back to no write, so an unknown select cannot infer a latch.
  always_comb begin
    wr_hit = 8'h00;
    if (WE && !CLR) begin
      case (sel)
        3'd0:    wr_hit = 8'h01;
        3'd1:    wr_hit = 8'h02;
        3'd2:    wr_hit = 8'h04;
        3'd3:    wr_hit = 8'h08;
        3'd4:    wr_hit = 8'h10;
        3'd5:    wr_hit = 8'h20;
        3'd6:    wr_hit = 8'h40;
        3'd7:    wr_hit = 8'h80;
        default: wr_hit = 8'h00;
      endcase
    end
`ifdef REG0_ZERO_EN
    // A write to slot 0 is dropped entirely, so it must not reach wr_any.
    wr_hit[0] = 1'b0;
`endif
  end

  assign wr_any = |wr_hit;

  // Per-slot storage. With REG0_ZERO_EN, slot 0 has no flop at all.
  for (genvar i = 0; i < 8; i++) begin : g_slot
`ifdef REG0_ZERO_EN
    if (i == 0) begin : g_zero
      assign slot_q[i]  = '0;
      assign valid_q[i] = 1'b0;
    end else begin : g_reg
`else
    begin : g_reg
`endif
      logic [WIDTH-1:0] data_q;
      logic             vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else if (CLR) begin
          data_q <= '0;
          vld_q  <= 1'b0;
        end else if (wr_hit[i]) begin
          data_q <= D;
          vld_q  <= 1'b1;
        end
      end

      assign slot_q[i]  = data_q;
      assign valid_q[i] = vld_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 3'd0;
    end else if (CLR) begin
      last_q <= 3'd0;
    end else if (wr_any) begin
      last_q <= sel;
    end
  end

  assign Y0   = slot_q[0];
  assign Y1   = slot_q[1];
  assign Y2   = slot_q[2];
  assign Y3   = slot_q[3];
  assign Y4   = slot_q[4];
  assign Y5   = slot_q[5];
  assign Y6   = slot_q[6];
  assign Y7   = slot_q[7];
  assign V    = valid_q;
  assign LAST = last_q;

endmodule

// File: tb/tb_demultiplexer_1_to_8_16_bit_reg.sv
module tb_demultiplexer_1_to_8_16_bit_reg;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [2:0]       sel;
  logic [WIDTH-1:0] d;
  logic             we;
  logic             clr;
  logic [WIDTH-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]       v;
  logic [2:0]       last;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0][WIDTH-1:0] y;
    logic [7:0]            v;
    logic [2:0]            last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mdl;

  demultiplexer_1_to_8_16_bit_reg #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .S2   (sel[2]),
    .S1   (sel[1]),
    .S0   (sel[0]),
    .D    (d),
    .WE   (we),
    .CLR  (clr),
    .Y0   (y0),
    .Y1   (y1),
    .Y2   (y2),
    .Y3   (y3),
    .Y4   (y4),
    .Y5   (y5),
    .Y6   (y6),
    .Y7   (y7),
    .V    (v),
    .LAST (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] dut_y(input int i);
    case (i)
      0: return y0;
      1: return y1;
      2: return y2;
      3: return y3;
      4: return y4;
      5: return y5;
      6: return y6;
      default: return y7;
    endcase
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_y%0d", tag, i), 32'(dut_y(i)), 32'(e.y[i]));
    check({tag, "_v"}, 32'(v), 32'(e.v));
    check({tag, "_last"}, 32'(last), 32'(e.last));
  endtask

  function automatic exp_t zero_state();
    exp_t z;
    z = '0;
    return z;
  endfunction

  // Reference behaviour for one clock edge.
  function automatic exp_t model_step(input exp_t cur, input logic w, input logic c,
                                      input logic [2:0] s, input logic [WIDTH-1:0] data);
    exp_t n;
    n = cur;
    if (c) begin
      n = '0;
    end else if (w) begin
`ifdef REG0_ZERO_EN
      if (s != 3'd0) begin
        n.y[s] = data;
        n.v[s] = 1'b1;
        n.last = s;
      end
`else
      n.y[s] = data;
      n.v[s] = 1'b1;
      n.last = s;
`endif
    end
    return n;
  endfunction

  // Drive one cycle away from the edge, push the expected result, then pop and
  // compare shortly after the sampling edge.
  task automatic cycle(input string tag, input logic w, input logic c,
                       input logic [2:0] s, input logic [WIDTH-1:0] data);
    exp_t e;
    @(negedge clk);
    we  = w;
    clr = c;
    sel = s;
    d   = data;
    mdl = model_step(mdl, w, c, s, data);
    exp_q.push_back(mdl);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got entries 0 expected 1", tag);
    end else begin
      e = exp_q.pop_front();
      compare_all(tag, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b1;
    clr   = 1'b0;
    sel   = 3'd0;
    d     = 16'hFFFF;
    mdl   = zero_state();

    // Reset held across edges with a pending write.
    repeat (3) @(posedge clk);
    #2;
    compare_all("rst_hold", zero_state());

    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;

    cycle("idle0", 1'b0, 1'b0, 3'd0, 16'h0000);
    cycle("single5", 1'b1, 1'b0, 3'd5, 16'hA5A5);
    cycle("single5_hold", 1'b0, 1'b0, 3'd0, 16'h0000);

    for (int i = 0; i < 8; i++)
      cycle($sformatf("sweep%0d", i), 1'b1, 1'b0, 3'(i), 16'h1000 + 16'(i));

    cycle("ovw_a", 1'b1, 1'b0, 3'd3, 16'h1234);
    cycle("ovw_b", 1'b1, 1'b0, 3'd3, 16'hBEEF);
    for (int i = 0; i < 4; i++)
      cycle($sformatf("hold%0d", i), 1'b0, 1'b0, 3'd3, 16'h0000);

    // Clear wins over a simultaneous write.
    cycle("clr_prio", 1'b1, 1'b1, 3'd2, 16'h5555);
    cycle("clr_idle", 1'b0, 1'b0, 3'd0, 16'h0000);

    cycle("r0_pre4", 1'b1, 1'b0, 3'd4, 16'h4444);
    cycle("r0_dead", 1'b1, 1'b0, 3'd0, 16'hDEAD);

    for (int i = 0; i < 24; i++)
      cycle($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
            16'($urandom));

    // Reset asserted mid-cycle during a write must clear without an edge.
    @(posedge clk);
    #2;
    we    = 1'b1;
    sel   = 3'd6;
    d     = 16'h7777;
    rst_n = 1'b0;
    #1;
    mdl = zero_state();
    compare_all("rst_async", mdl);
    @(posedge clk);
    #1;
    compare_all("rst_async_edge", mdl);
    @(negedge clk);
    we    = 1'b0;
    rst_n = 1'b1;
    cycle("post_rst7", 1'b1, 1'b0, 3'd7, 16'hC0DE);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
